// File: rtl/seq_div32.sv
// Sequential signed divider: one quotient bit per clock via non-restoring division.
// Result is {remainder, quotient}; remainder follows the dividend's sign.
module seq_div32 #(
  parameter int WORD = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [WORD-1:0]   dividend,
  input  logic [WORD-1:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [2*WORD-1:0] out
);

  localparam int CW = $clog2(WORD);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state, state_nxt;
  logic [WORD:0]   r;
  logic [WORD-1:0] q, d;
  logic [CW-1:0]   cnt;
  logic            qsign, rsign;
  logic            accept, zero_op;

  logic [WORD-1:0] abs_a, abs_b;
  logic [WORD:0]   r_sh, r_step;
  logic [WORD-1:0] q_step, r_fix, r_out, q_out;

  // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude
  assign abs_a = dividend[WORD-1] ? -dividend : dividend;
  assign abs_b = divisor[WORD-1]  ? -divisor  : divisor;

  // Add/subtract choice is made on the sign of R before the shift
  assign r_sh   = {r[WORD-1:0], q[WORD-1]};
  assign r_step = r[WORD] ? r_sh + {1'b0, d} : r_sh - {1'b0, d};
  assign q_step = {q[WORD-2:0], ~r_step[WORD]};

  // Restored remainder lies in [0, D), so the low WORD bits suffice
  assign r_fix = r[WORD] ? r[WORD-1:0] + d : r[WORD-1:0];
  assign r_out = rsign ? -r_fix : r_fix;
  assign q_out = qsign ? -q : q;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_op   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            zero_op = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = CALC;
          end
        end
      end
      CALC:    if (cnt == CW'(WORD-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      out      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        r     <= '0;
        q     <= abs_a;
        d     <= abs_b;
        cnt   <= '0;
        qsign <= dividend[WORD-1] ^ divisor[WORD-1];
        rsign <= dividend[WORD-1];
      end
      if (zero_op) begin
        out      <= {dividend, {WORD{1'b1}}};
        div_zero <= 1'b1;
        done     <= 1'b1;
      end
      if (state == CALC) begin
        r   <= r_step;
        q   <= q_step;
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        out      <= {r_out, q_out};
        div_zero <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Bench for seq_div32: cycle-level scoreboard built on plain signed arithmetic,
// directed literal cases from the test plan, then randomized traffic with aborts.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        clr;
  logic        start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_zero;
  logic [63:0] out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  seq_div32 #(.WORD(32)) dut (
    .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero), .out(out)
  );

  always #5 clk = ~clk;

  // Reference result straight from the arithmetic rules
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Scoreboard: op accepted when idle, completes 33 edges later
  int          m_left = 0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [63:0] m_out = '0, m_pend = '0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_left = 0; m_done = 1'b0; m_dz = 1'b0; m_out = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_out = m_pend; m_dz = 1'b0;
        end
      end else if (start) begin
        if (divisor == 32'd0) begin
          m_done = 1'b1; m_dz = 1'b1; m_out = ref_div(dividend, divisor);
        end else begin
          m_left = 33; m_pend = ref_div(dividend, divisor);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      check("out", out, m_out);
      check("div_zero", 64'(div_zero), 64'(m_dz));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a cycle budget; returns cycles waited
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] eo, input logic edz, input string nm);
    int n;
    dividend = a; divisor = b; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check({nm, " latency"}, 64'(n), (b == 32'd0) ? 64'd0 : 64'd33);
    check({nm, " out"}, out, eo);
    check({nm, " dz"}, 64'(div_zero), 64'(edz));
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bit seen;
    clr = 1'b1;
    step(); step();
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz", 64'(div_zero), 64'd0);
    check("rst out", out, 64'd0);
    clr = 1'b0;
    chk_en = 1'b1;
    step();

    run_op(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "100/7");
    run_op(-32'sd100, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0, "-100/7");
    run_op(32'd100, -32'sd7, 64'h00000002_FFFFFFF2, 1'b0, "100/-7");
    run_op(32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, "5/0");
    run_op(32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "9/3");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, "min/-1");
    run_op(32'h8000_0000, 32'd2, 64'h00000000_C0000000, 1'b0, "min/2");

    // Start while busy is ignored; start in the done cycle is accepted
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check("ignored start out", out, 64'h00000000_00000064);
    dividend = 32'd7; divisor = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check("back-to-back latency", 64'(n), 64'd33);
    check("back-to-back out", out, 64'h00000001_00000003);
    step();

    // Abort in flight
    dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    clr = 1'b1;
    #1;
    check("clr busy", 64'(busy), 64'd0);
    check("clr out", out, 64'd0);
    check("clr dz", 64'(div_zero), 64'd0);
    step(); step();
    clr = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (done) seen = 1'b1;
    end
    check("no done after clr", 64'(seen), 64'd0);
    run_op(32'd50, 32'd3, 64'h00000002_00000010, 1'b0, "50/3");

    // Random traffic: scoreboard checks every cycle
    for (int i = 0; i < 8000; i++) begin
      start    = ($urandom_range(0, 3) == 0) || (i >= 6000 && i < 6400);
      dividend = pick();
      divisor  = pick();
      clr      = ($urandom_range(0, 799) == 0);
      step();
    end
    clr = 1'b0; start = 1'b0;
    repeat (40) step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_div32.md
# seq_div32

Sequential signed 32-bit divider for the datapath's `div` operation. It accepts a dividend and divisor on a start pulse and iterates one quotient bit per clock using non-restoring division. It returns a 64-bit result with the remainder in `[63:32]` and the quotient in `[31:0]`. The ALU forwards that result unchanged onto its 64-bit C output, and from there it is captured into Z (HI = remainder, LO = quotient).

## Interface
- `WORD`, 32 — operand width. The result is 2*WORD bits. Only 32 is verified.

Ports, clock and reset first:
- `clk` — in, 1 — single clock, rising edge.
- `clr` — in, 1 — asynchronous, active-high reset.
- `start` — in, 1 — request a division. Sampled only in IDLE.
- `dividend` — in, 32 — two's-complement dividend. Sampled on the accepted start edge.
- `divisor` — in, 32 — two's-complement divisor. Sampled on the accepted start edge.
- `busy` — out, 1 — high while a division is in progress.
- `done` — out, 1 — one-cycle pulse when `out` holds a new result.
- `div_zero` — out, 1 — high when the divisor of the last completed op was 0. Held until the next completion.
- `out` — out, 64 — `{remainder, quotient}`. Held until the next completion.

## Operation
States are IDLE, CALC and FIX.

IDLE:
- `start`=1 with `divisor`≠0: register |dividend|, |divisor|, the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]). Clear the 33-bit partial remainder, clear the 5-bit iteration counter, then go to CALC.
- `start`=1 with `divisor`=0: load `out` = {dividend, 32'hFFFFFFFF}, set `div_zero`=1, pulse `done`, and stay in IDLE.

CALC runs exactly 32 iterations, one per cycle:
- Shift {R, Q} left by one.
- If R ≥ 0, R = R − D; otherwise R = R + D.
- Q[0] = ~R[32] after the update.
- The counter wraps from 31 to FIX.

FIX takes one cycle:
- If R < 0, R = R + D.
- Negate Q if the quotient sign is set.
- Negate R if the remainder sign is set.
- Load `out` = {R[31:0], Q}, set `div_zero`=0, pulse `done`, then go to IDLE.

Result rules:
- The quotient truncates toward zero.
- The remainder takes the dividend's sign; a zero remainder is always 0.
- |−2^31| is handled as the 32-bit magnitude 0x80000000, with no overflow in the 33-bit R.
- −2^31 / −1 gives quotient 0x80000000 and remainder 0. The result wraps and no flag is raised.

Other rules:
- `start` while `busy`=1 is ignored. Operands may change freely while busy.
- `clr` asserted at any time forces IDLE and aborts any op in flight. No `done` is produced for the aborted op.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `out`=64'd0, state IDLE, counter 0.
- Accepted start edge = E0:
  - `busy` is 1 from after E0 through E33.
  - `busy` falls and `done`=1 after E33, i.e. in the cycle following 33 edges. Latency is 33 cycles.
- Divide by zero: `done`=1 and `out` valid in the cycle after E0. `busy` never rises.
- `done` lasts exactly one cycle. `out` and `div_zero` update on the same edge that raises `done`.
- `start`=1 during the `done` cycle is accepted, because the state is IDLE. The new op's E0 is the following edge, and `done` drops on it.
- `start` held high continuously: the block starts a new op immediately after each completion.

## Test plan
- 100 / 7 → `done` after 33 edges; `out`=0x00000002_0000000E; `div_zero`=0; `busy` high for 33 cycles.
- −100 / 7 → `out`=0xFFFFFFFE_FFFFFFF2. Also 100 / −7 → `out`=0x00000002_FFFFFFF2.
- 5 / 0 → `done` in the cycle after the start edge; `out`=0x00000005_FFFFFFFF; `div_zero`=1. A following 9 / 3 → `out`=0x00000000_00000003 and `div_zero`=0.
- 0x80000000 / 0xFFFFFFFF → `out`=0x00000000_80000000. Also 0x80000000 / 2 → `out`=0x00000000_C0000000.
- Start 1000 / 10, pulse `start` again with other operands at cycle 5:
  - The second start is ignored and `out`=0x00000000_00000064.
  - Assert `start` during the `done` cycle with 7 / 2 → the next `done` comes 33 edges later with `out`=0x00000001_00000003.
- Start 50 / 3, assert `clr` at cycle 10 → `busy`=0, `out`=0 and `div_zero`=0 immediately. No `done` for the next 40 cycles. After `clr` deasserts, 50 / 3 → `out`=0x00000002_00000010.
